// File: rtl/alu_issue_queue_if.sv
// Dispatch, wakeup and issue bundle between the rename/dispatch side and the
// ALU issue queue.
interface alu_issue_queue_if;
  logic        in_valid;
  logic [3:0]  in_Conf;
  logic [5:0]  in_Pa;
  logic [5:0]  in_Pb;
  logic        in_rdyA;
  logic        in_rdyB;
  logic [5:0]  in_Pd;
  logic        in_RegWr;
  logic [5:0]  in_tag_rob;
  logic        full;
  logic [1:0]  wake_valid;
  logic [11:0] wake_Pd;
  logic [3:0]  Conf;
  logic [5:0]  Pa;
  logic [5:0]  Pb;
  logic [5:0]  Pd;
  logic        ready;
  logic        RegWr;
  logic [5:0]  tag_rob;

  modport slave (
    input  in_valid, in_Conf, in_Pa, in_Pb, in_rdyA, in_rdyB, in_Pd, in_RegWr,
           in_tag_rob, wake_valid, wake_Pd,
    output full, Conf, Pa, Pb, Pd, ready, RegWr, tag_rob
  );

  modport master (
    output in_valid, in_Conf, in_Pa, in_Pb, in_rdyA, in_rdyB, in_Pd, in_RegWr,
           in_tag_rob, wake_valid, wake_Pd,
    input  full, Conf, Pa, Pb, Pd, ready, RegWr, tag_rob
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Collapsing ALU issue queue: holds dispatched micro-ops until both sources are
// ready and issues the oldest ready entry per cycle on registered outputs.
module alu_issue_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_back,
  alu_issue_queue_if.slave q
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0] conf;
    logic [5:0] pa;
    logic [5:0] pb;
    logic       rdy_a;
    logic       rdy_b;
    logic [5:0] pd;
    logic       reg_wr;
    logic [5:0] tag;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           new_e;
  entry_t           out_q;
  logic             ready_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] sel_idx;
  logic [CNT_W-1:0] wr_idx;
  logic             has_sel;
  logic             accept;
  logic             full_c;

  function automatic logic wake_hit(input logic [5:0] tag, input logic [1:0] wv,
                                    input logic [11:0] wp);
    return (wv[0] && (wp[5:0] == tag)) || (wv[1] && (wp[11:6] == tag));
  endfunction

  // Oldest ready entry; scanning downward leaves the lowest index selected.
  always_comb begin
    has_sel = 1'b0;
    sel_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < count_q) && ent_q[i].rdy_a && ent_q[i].rdy_b) begin
        has_sel = 1'b1;
        sel_idx = CNT_W'(i);
      end
    end
  end

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign accept  = q.in_valid && !full_c;
  assign wr_idx  = count_q - CNT_W'(has_sel);
  assign count_d = count_q + CNT_W'(accept) - CNT_W'(has_sel);

  // Compaction, wakeup and dispatch for every slot in one pass.
  always_comb begin
    new_e.conf   = q.in_Conf;
    new_e.pa     = q.in_Pa;
    new_e.pb     = q.in_Pb;
    new_e.rdy_a  = q.in_rdyA | wake_hit(q.in_Pa, q.wake_valid, q.wake_Pd);
    new_e.rdy_b  = q.in_rdyB | wake_hit(q.in_Pb, q.wake_valid, q.wake_Pd);
    new_e.pd     = q.in_Pd;
    new_e.reg_wr = q.in_RegWr;
    new_e.tag    = q.in_tag_rob;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_d[i] = ent_q[i];
      if (has_sel && (CNT_W'(i) >= sel_idx) && (i < int'(DEPTH) - 1))
        ent_d[i] = ent_q[(i + 1) % int'(DEPTH)];
      ent_d[i].rdy_a = ent_d[i].rdy_a | wake_hit(ent_d[i].pa, q.wake_valid, q.wake_Pd);
      ent_d[i].rdy_b = ent_d[i].rdy_b | wake_hit(ent_d[i].pb, q.wake_valid, q.wake_Pd);
      if (accept && (CNT_W'(i) == wr_idx))
        ent_d[i] = new_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
    end else if (flush_back) begin
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  // Issue register: fields hold when nothing issues, only the strobe drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      ready_q <= 1'b0;
    end else if (flush_back) begin
      out_q   <= '0;
      ready_q <= 1'b0;
    end else if (has_sel) begin
      out_q   <= ent_q[IDX_W'(sel_idx)];
      ready_q <= 1'b1;
    end else begin
      ready_q <= 1'b0;
    end
  end

  assign q.full    = full_c;
  assign q.Conf    = out_q.conf;
  assign q.Pa      = out_q.pa;
  assign q.Pb      = out_q.pb;
  assign q.Pd      = out_q.pd;
  assign q.RegWr   = out_q.reg_wr;
  assign q.tag_rob = out_q.tag;
  assign q.ready   = ready_q;

endmodule
